// File: rtl/cmi_mem_resp.sv
// CMI memory responder: accepts command/address and write-data cycles, returns read data after
// a fixed latency, and implements the read-lock / write-unlock interlock over a longword store.
module cmi_mem_resp #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        b_clk_l,
  input  logic        bus_init_l,
  input  logic        cmi_cmd_vld_h,
  input  logic [3:0]  cmi_func_h,
  input  logic [3:0]  cmi_mask_h,
  input  logic [31:0] cmi_d_in_h,
  output logic [31:0] cmi_d_out_h,
  output logic        cmi_d_oe_h,
  output logic        cmi_stall_h,
  output logic        cmi_rd_vld_h,
  output logic        cmi_nxm_h,
  output logic        cmi_retry_h,
  output logic        lock_h
);

  localparam logic [3:0] FnRead     = 4'b0001;
  localparam logic [3:0] FnWrite    = 4'b0010;
  localparam logic [3:0] FnRdLock   = 4'b0011;
  localparam logic [3:0] FnWrUnlock = 4'b0100;
  localparam logic [3:0] LatM1      = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWdata, StRwait, StRdrv} state_e;

  state_e            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_func;
  logic              r_nxm;
  logic              r_lock_held;
  logic              r_lock, w_lock_nxt;
  logic [31:0]       r_mem [2**ADDR_W];

  logic [31:0]       r_d_out, w_d_out_nxt;
  logic              r_oe, w_oe_nxt;
  logic              r_stall, w_stall_nxt;
  logic              r_rd_vld, w_rd_vld_nxt;
  logic              r_nxm_out, w_nxm_out_nxt;
  logic              r_retry, w_retry_nxt;

  logic              w_func_legal, w_accept, w_is_read, w_addr_nxm, w_from_idle;
  logic [3:0]        w_func_eff;
  logic [ADDR_W-1:0] w_addr_eff;
  logic              w_nxm_eff, w_held_eff, w_retry_eff, w_mem_we;

  assign w_func_legal = (cmi_func_h >= FnRead) && (cmi_func_h <= FnWrUnlock);
  assign w_accept     = (r_state == StIdle) && cmi_cmd_vld_h && w_func_legal;
  assign w_is_read    = (cmi_func_h == FnRead) || (cmi_func_h == FnRdLock);
  assign w_addr_nxm   = (cmi_d_in_h[23:0] >> ADDR_W) != 24'd0;

  // With LATENCY=1 RDRV is entered straight from IDLE, so its outputs come from the bus.
  assign w_from_idle = (r_state == StIdle);
  assign w_func_eff  = w_from_idle ? cmi_func_h : r_func;
  assign w_addr_eff  = w_from_idle ? cmi_d_in_h[ADDR_W-1:0] : r_addr;
  assign w_nxm_eff   = w_from_idle ? w_addr_nxm : r_nxm;
  assign w_held_eff  = w_from_idle ? r_lock : r_lock_held;
  assign w_retry_eff = (w_func_eff == FnRdLock) && w_held_eff;
  assign w_mem_we    = (r_state == StWdata) && !r_nxm && bus_init_l;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!w_is_read) begin
            w_state_nxt = StWdata;
          end else if (LATENCY == 1) begin
            w_state_nxt = StRdrv;
          end else begin
            w_state_nxt = StRwait;
            w_cnt_nxt   = LatM1;
          end
        end
      end
      StRwait: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = StRdrv;
      end
      StWdata: w_state_nxt = StIdle;
      StRdrv:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_lock_nxt = r_lock;
    if (r_state == StRdrv && r_func == FnRdLock && !r_lock_held) w_lock_nxt = 1'b1;
    if (r_state == StWdata && r_func == FnWrUnlock) w_lock_nxt = 1'b0;
  end

  // Outputs are registered against the state being entered so pulses are glitch-free.
  always_comb begin
    w_stall_nxt   = (w_state_nxt != StIdle);
    w_rd_vld_nxt  = 1'b0;
    w_oe_nxt      = 1'b0;
    w_nxm_out_nxt = 1'b0;
    w_retry_nxt   = 1'b0;
    w_d_out_nxt   = '0;
    if (w_state_nxt == StRdrv) begin
      w_retry_nxt   = w_retry_eff;
      w_rd_vld_nxt  = !w_retry_eff;
      w_oe_nxt      = !w_retry_eff;
      w_nxm_out_nxt = !w_retry_eff && w_nxm_eff;
      if (!w_retry_eff && !w_nxm_eff) w_d_out_nxt = r_mem[w_addr_eff];
    end else if (w_state_nxt == StWdata) begin
      w_nxm_out_nxt = w_nxm_eff;
    end
  end

  always_ff @(posedge b_clk_l or negedge bus_init_l) begin
    if (!bus_init_l) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_func      <= '0;
      r_nxm       <= 1'b0;
      r_lock_held <= 1'b0;
      r_lock      <= 1'b0;
      r_d_out     <= '0;
      r_oe        <= 1'b0;
      r_stall     <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_nxm_out   <= 1'b0;
      r_retry     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr      <= cmi_d_in_h[ADDR_W-1:0];
        r_func      <= cmi_func_h;
        r_nxm       <= w_addr_nxm;
        r_lock_held <= r_lock;
      end
      r_lock    <= w_lock_nxt;
      r_d_out   <= w_d_out_nxt;
      r_oe      <= w_oe_nxt;
      r_stall   <= w_stall_nxt;
      r_rd_vld  <= w_rd_vld_nxt;
      r_nxm_out <= w_nxm_out_nxt;
      r_retry   <= w_retry_nxt;
    end
  end

  // Store contents survive reset.
  always_ff @(posedge b_clk_l) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cmi_mask_h[b]) r_mem[r_addr][8*b +: 8] <= cmi_d_in_h[8*b +: 8];
      end
    end
  end

  assign cmi_d_out_h  = r_d_out;
  assign cmi_d_oe_h   = r_oe;
  assign cmi_stall_h  = r_stall;
  assign cmi_rd_vld_h = r_rd_vld;
  assign cmi_nxm_h    = r_nxm_out;
  assign cmi_retry_h  = r_retry;
  assign lock_h       = r_lock;

endmodule

// File: tb/tb_cmi_mem_resp.sv
// Bench for cmi_mem_resp: directed vector table, multi-cycle corner sequences, and random
// transactions checked against a transaction-level memory/interlock model.
module tb_cmi_mem_resp;

  localparam int unsigned AW    = 10;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic        b_clk_l = 1'b0;
  logic        bus_init_l = 1'b0;
  logic        cmi_cmd_vld_h = 1'b0;
  logic [3:0]  cmi_func_h = 4'h0;
  logic [3:0]  cmi_mask_h = 4'h0;
  logic [31:0] cmi_d_in_h = 32'h0;
  logic [31:0] cmi_d_out_h;
  logic        cmi_d_oe_h, cmi_stall_h, cmi_rd_vld_h, cmi_nxm_h, cmi_retry_h, lock_h;

  cmi_mem_resp #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .b_clk_l      (b_clk_l),
    .bus_init_l   (bus_init_l),
    .cmi_cmd_vld_h(cmi_cmd_vld_h),
    .cmi_func_h   (cmi_func_h),
    .cmi_mask_h   (cmi_mask_h),
    .cmi_d_in_h   (cmi_d_in_h),
    .cmi_d_out_h  (cmi_d_out_h),
    .cmi_d_oe_h   (cmi_d_oe_h),
    .cmi_stall_h  (cmi_stall_h),
    .cmi_rd_vld_h (cmi_rd_vld_h),
    .cmi_nxm_h    (cmi_nxm_h),
    .cmi_retry_h  (cmi_retry_h),
    .lock_h       (lock_h)
  );

  always #5 b_clk_l = ~b_clk_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference state.
  logic [31:0] m_mem [DEPTH];
  bit          m_lock;

  typedef struct {
    bit          is_wr;
    bit          lk;
    logic [23:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_d;
    bit          exp_nxm;
    bit          exp_retry;
    bit          exp_lock;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge b_clk_l);
    #1;
  endtask

  task automatic do_read(input logic [23:0] addr, input bit lk, input logic [31:0] exp_d,
                         input bit exp_nxm, input bit exp_retry, input bit exp_lock);
    chk("rd_pre_stall", cmi_stall_h, 0);
    cmi_cmd_vld_h = 1'b1;
    cmi_func_h    = lk ? 4'b0011 : 4'b0001;
    cmi_d_in_h    = {8'($urandom), addr};
    step();
    cmi_cmd_vld_h = 1'b0;
    cmi_d_in_h    = $urandom;
    for (int k = 1; k <= int'(LAT); k++) begin
      chk("rd_stall", cmi_stall_h, 1);
      if (k < int'(LAT)) begin
        chk("rd_early_vld", cmi_rd_vld_h, 0);
        step();
      end else begin
        chk("rd_vld", cmi_rd_vld_h, !exp_retry);
        chk("rd_oe", cmi_d_oe_h, !exp_retry);
        chk("rd_nxm", cmi_nxm_h, exp_nxm);
        chk("rd_retry", cmi_retry_h, exp_retry);
        if (!exp_retry) chk("rd_data", cmi_d_out_h, exp_d);
      end
    end
    step();
    chk("rd_post_stall", cmi_stall_h, 0);
    chk("rd_post_vld", cmi_rd_vld_h, 0);
    chk("rd_lock", lock_h, exp_lock);
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] mask,
                          input bit unl, input bit exp_nxm, input bit exp_lock);
    chk("wr_pre_stall", cmi_stall_h, 0);
    cmi_cmd_vld_h = 1'b1;
    cmi_func_h    = unl ? 4'b0100 : 4'b0010;
    cmi_d_in_h    = {8'($urandom), addr};
    step();
    cmi_cmd_vld_h = 1'b0;
    chk("wr_stall", cmi_stall_h, 1);
    chk("wr_nxm", cmi_nxm_h, exp_nxm);
    chk("wr_vld", cmi_rd_vld_h, 0);
    cmi_d_in_h = data;
    cmi_mask_h = mask;
    step();
    cmi_d_in_h = $urandom;
    cmi_mask_h = 4'($urandom);
    chk("wr_post_stall", cmi_stall_h, 0);
    chk("wr_post_nxm", cmi_nxm_h, 0);
    chk("wr_lock", lock_h, exp_lock);
  endtask

  function automatic bit is_nxm(input logic [23:0] a);
    return int'(a) >= int'(DEPTH);
  endfunction

  task automatic model_read(input logic [23:0] addr, input bit lk);
    bit nx, rt;
    logic [31:0] d;
    nx = is_nxm(addr);
    rt = lk && m_lock;
    d  = nx ? 32'h0 : m_mem[addr[AW-1:0]];
    if (lk && !rt) m_lock = 1'b1;
    do_read(addr, lk, d, nx && !rt, rt, m_lock);
  endtask

  task automatic model_write(input logic [23:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input bit unl);
    bit nx;
    nx = is_nxm(addr);
    if (!nx) begin
      for (int b = 0; b < 4; b++) if (mask[b]) m_mem[addr[AW-1:0]][8*b +: 8] = data[8*b +: 8];
    end
    if (unl) m_lock = 1'b0;
    do_write(addr, data, mask, unl, nx, m_lock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 24'h000005, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 24'h000005, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 24'h000005, 32'h11223344, 4'h5, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 24'h000005, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 24'h000400, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 24'h000000, 32'h55AA55AA, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 24'h000400, 32'h12345678, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 24'h000000, 32'h0,        4'h0, 32'h55AA55AA, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 24'h000010, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 24'h000010, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 24'h000010, 32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 24'h000010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 24'h000010, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 24'h000400, 32'h0,        4'hF, 32'h0,        1'b1, 1'b0, 1'b0};

    // Reset state.
    step();
    step();
    chk("rst_stall", cmi_stall_h, 0);
    chk("rst_oe", cmi_d_oe_h, 0);
    chk("rst_vld", cmi_rd_vld_h, 0);
    chk("rst_dout", cmi_d_out_h, 0);
    chk("rst_lock", lock_h, 0);
    chk("rst_nxm", cmi_nxm_h | cmi_retry_h, 0);
    bus_init_l = 1'b1;
    step();

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_wr)
        do_write(tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].lk, tbl[i].exp_nxm,
                 tbl[i].exp_lock);
      else
        do_read(tbl[i].addr, tbl[i].lk, tbl[i].exp_d, tbl[i].exp_nxm, tbl[i].exp_retry,
                tbl[i].exp_lock);
    end

    // Command held through a read: second accept only on the edge after RDRV.
    cmi_cmd_vld_h = 1'b1;
    cmi_func_h    = 4'b0001;
    cmi_d_in_h    = 32'h0000_0005;
    step();
    for (int k = 1; k <= 2 * int'(LAT) + 2; k++) begin
      chk("hold_vld", cmi_rd_vld_h, (k == int'(LAT)) || (k == 2 * int'(LAT) + 1));
      chk("hold_stall", cmi_stall_h, (k != int'(LAT) + 1) && (k != 2 * int'(LAT) + 2));
      if (k == int'(LAT)) chk("hold_data", cmi_d_out_h, 32'hDE22BE44);
      if (k == 2 * int'(LAT) + 2) cmi_cmd_vld_h = 1'b0;
      else step();
    end

    // Reserved function code is ignored.
    cmi_cmd_vld_h = 1'b1;
    cmi_func_h    = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rsv_stall", cmi_stall_h, 0);
      chk("rsv_resp", {cmi_rd_vld_h, cmi_d_oe_h, cmi_nxm_h, cmi_retry_h}, 0);
    end
    cmi_cmd_vld_h = 1'b0;

    // Reset during WDATA aborts the write and clears the interlock.
    do_write(24'h20, 32'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    do_read(24'h20, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    cmi_cmd_vld_h = 1'b1;
    cmi_func_h    = 4'b0010;
    cmi_d_in_h    = 32'h0000_0020;
    step();
    cmi_cmd_vld_h = 1'b0;
    chk("abort_in_wdata", cmi_stall_h, 1);
    cmi_d_in_h = 32'hCAFEF00D;
    cmi_mask_h = 4'hF;
    #2;
    bus_init_l = 1'b0;
    #1;
    chk("abort_stall", cmi_stall_h, 0);
    chk("abort_lock", lock_h, 0);
    chk("abort_outs", {cmi_d_oe_h, cmi_rd_vld_h, cmi_nxm_h, cmi_retry_h}, 0);
    chk("abort_dout", cmi_d_out_h, 0);
    step();
    bus_init_l = 1'b1;
    step();
    do_read(24'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Randomized transactions against the reference model.
    m_lock = 1'b0;
    for (int a = 0; a < 8; a++) model_write(24'(a), $urandom, 4'hF, 1'b0);
    for (int n = 0; n < 250; n++) begin
      int sel;
      logic [23:0] addr;
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) addr = {14'($urandom_range(1, 16383)), 10'($urandom)};
      else addr = 24'($urandom_range(0, 7));
      if (sel <= 2)      model_read(addr, 1'b0);
      else if (sel <= 4) model_read(addr, 1'b1);
      else if (sel <= 7) model_write(addr, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      else if (sel == 8) model_write(addr, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      else begin
        int r;
        r = $urandom_range(4, 15);
        cmi_cmd_vld_h = 1'b1;
        cmi_func_h    = (r == 4) ? 4'h0 : 4'(r);
        cmi_d_in_h    = $urandom;
        step();
        cmi_cmd_vld_h = 1'b0;
        chk("rnd_rsv_stall", cmi_stall_h, 0);
        chk("rnd_rsv_lock", lock_h, m_lock);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmi_mem_resp.md
Name: cmi_mem_resp

Overview:
- CMI responder: the memory end of the CMI transfers that the MDR slices initiate.
- Accepts command/address cycles and write-data cycles from the CPU side of the CMI.
- Returns read data after a fixed, parameterised latency. Implements the interlock (read-lock / write-unlock) semantics.
- Holds a behavioural longword store. Serves as the memory model for CPU-side simulation and as the datapath core of the memory controller.

Parameters:
- ADDR_W, 10, longword address bits decoded; store depth is 2**ADDR_W longwords.
- LATENCY, 2, cycles from command accept to the read-data drive cycle; legal range 1..15.

Ports:
- b_clk_l  in  1  system clock; all registers sample on its rising edge.
- bus_init_l  in  1  asynchronous active-low reset.
- cmi_cmd_vld_h  in  1  initiator presents a command/address cycle this clock.
- cmi_func_h  in  4  function: 0001 read, 0010 write, 0011 read-lock, 0100 write-unlock; all other codes reserved.
- cmi_mask_h  in  4  byte-write mask, sampled in the data cycle; bit n enables byte n.
- cmi_d_in_h  in  32  CMI data lines as received. Address cycle: bits 23:0 are the longword address. Data cycle: write data.
- cmi_d_out_h  out  32  read data driven to the CMI.
- cmi_d_oe_h  out  1  data driver enable; cmi_d_out_h is meaningful only while this is high.
- cmi_stall_h  out  1  responder busy; commands presented while high are not accepted.
- cmi_rd_vld_h  out  1  read data valid this cycle.
- cmi_nxm_h  out  1  non-existent memory for the current transfer.
- cmi_retry_h  out  1  read-lock refused because the interlock is held.
- lock_h  out  1  interlock flag, exported for status.

Behaviour:
- Reset (bus_init_l low, asynchronous):
  - state IDLE, lock_h 0, counter 0.
  - All outputs 0.
  - Store contents are not reset.
  - Reset during any state aborts the transfer; no store write occurs.
- States: IDLE, WDATA, RWAIT, RDRV.
- IDLE: cmi_stall_h 0. A command is accepted at a clock edge when cmi_cmd_vld_h=1 and cmi_func_h is not reserved. At that edge the responder registers:
  - address = cmi_d_in_h[23:0];
  - function;
  - nxm_q = (address[23:ADDR_W] != 0).
- Reserved function: not accepted; no state change, no response.
- Read / read-lock accept:
  - LATENCY=1: go to RDRV.
  - Otherwise: go to RWAIT with counter = LATENCY-1.
- RWAIT: stall 1. Counter decrements each clock; go to RDRV when it reaches 1.
- RDRV (exactly one cycle): stall 1, then return to IDLE.
  - Normal read: rd_vld 1, oe 1, d_out = store[address].
  - nxm_q: nxm 1, rd_vld 1, oe 1, d_out 0.
  - Read-lock with lock_h already 1 at accept time: retry 1, rd_vld 0, oe 0, nxm 0, lock unchanged.
  - Read-lock otherwise, including nxm_q: lock_h is set at the end of RDRV.
- Write / write-unlock accept: go to WDATA.
- WDATA (exactly one cycle): stall 1; cmi_d_in_h and cmi_mask_h sampled at its end.
  - nxm_q=0: bytes with mask bit 1 are written to store[address].
  - nxm_q=1: no write; nxm 1 during WDATA.
  - Write-unlock: lock_h cleared at the end of WDATA, even on NXM and even if lock_h is already 0.
  - Plain write does not touch lock_h.
  - Return to IDLE.
- Latency rules:
  - The read data cycle is exactly LATENCY cycles after the accept edge.
  - The earliest next accept is the edge ending the cycle after RDRV or WDATA. Back-to-back read throughput is therefore one transfer per LATENCY+1 cycles.
- cmi_cmd_vld_h is ignored whenever stall is 1. The initiator holds the command; no queueing.
- A write to an address followed by a read of the same address returns the new data. This follows from sequential states; no bypass is needed.
- rd_vld, nxm and retry are single-cycle pulses, registered, glitch-free. Each is asserted only in RDRV or WDATA.
- The store is a synchronous-write, combinational-read array. A single port suffices because reads and writes never overlap.

Test Plan:
- Reset, then write 0xDEADBEEF with mask 1111 to address 0x000005, then read 0x000005 with LATENCY=2 -> rd_vld and oe high exactly 2 cycles after the read accept; d_out 0xDEADBEEF; stall high for 2 cycles.
- Write 0x11223344 mask 0101 over 0xDEADBEEF at 0x000005, then read -> 0xDE22BE44.
- Read 0x000400 (ADDR_W=10) -> nxm 1 and rd_vld 1 with d_out 0. Write 0x000400 -> nxm 1 in WDATA; a subsequent read of 0x000000 is unaffected.
- Read-lock 0x10 -> data returned, lock_h 1. Second read-lock 0x10 -> retry 1, rd_vld 0, lock stays 1. Write-unlock 0x10 -> lock_h 0. Third read-lock succeeds.
- Hold cmi_cmd_vld_h=1 with a read throughout a read in progress -> the second command is accepted only on the edge after RDRV. Func 0111 presented in IDLE -> no stall, no response.
- Assert bus_init_l low during WDATA of a write of 0xCAFEF00D to 0x20 after the store held 0x0 there -> all outputs 0 immediately; a later read of 0x20 returns 0x0; lock_h 0.
